// File: rtl/i2s_sample_tx_if.sv
// Sample-path to I2S transmitter bus: upstream sample pair in, codec serial lines and frame pulses out.
// The master modport is the upstream voice; the slave modport is the transmitter.
interface i2s_sample_tx_if #(
  parameter int SAMPLE_BITS = 16
);
  logic signed [SAMPLE_BITS-1:0] sample_l;
  logic signed [SAMPLE_BITS-1:0] sample_r;
  logic                          in_valid;
  logic                          sample_req;
  logic                          underrun;
  logic                          bclk;
  logic                          pblrc;
  logic                          pbdat;

  modport master (
    output sample_l, sample_r, in_valid,
    input  sample_req, underrun, bclk, pblrc, pbdat
  );

  modport slave (
    input  sample_l, sample_r, in_valid,
    output sample_req, underrun, bclk, pblrc, pbdat
  );
endinterface

// File: rtl/i2s_sample_tx.sv
// Philips I2S transmitter: one free-running 8-bit mclk counter sets bclk, pblrc and the bit slot;
// a stereo pair is latched at each frame wrap and shifted out MSB first with the one-bit I2S delay.
module i2s_sample_tx #(
  parameter int SAMPLE_BITS = 16,
  parameter bit MONO        = 1'b0
) (
  input logic          mclk,
  input logic          rst_n,
  i2s_sample_tx_if.slave bus
);

  logic [7:0]                    c_q, c_d;
  logic signed [SAMPLE_BITS-1:0] hold_l_q, hold_l_d;
  logic signed [SAMPLE_BITS-1:0] hold_r_q, hold_r_d;
  logic signed [SAMPLE_BITS-1:0] h_sel;
  logic                          latch;
  logic                          bclk_q, bclk_d;
  logic                          pblrc_q, pblrc_d;
  logic                          pbdat_q, pbdat_d;
  logic                          req_q, req_d;
  logic                          ur_q, ur_d;

  // Slot bit s of word h: s=0 is the I2S delay bit, beyond SAMPLE_BITS is zero padding.
  function automatic logic slot_bit(input logic signed [SAMPLE_BITS-1:0] h,
                                    input logic [4:0] s);
    logic bit_v;
    bit_v = 1'b0;
    for (int i = 0; i < SAMPLE_BITS; i++) begin
      if (int'(s) == SAMPLE_BITS - i) bit_v = h[i];
    end
    return bit_v;
  endfunction

  always_comb begin
    latch    = (c_q == 8'd255);
    c_d      = c_q + 8'd1;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    if (latch) begin
      if (bus.in_valid) begin
        hold_l_d = bus.sample_l;
        hold_r_d = MONO ? bus.sample_l : bus.sample_r;
      end else begin
        hold_l_d = '0;
        hold_r_d = '0;
      end
    end
    // The latch edge loads c=0 whose slot bit needs no hold data, so the old hold is safe to read.
    h_sel   = c_d[7] ? hold_r_q : hold_l_q;
    pbdat_d = slot_bit(h_sel, c_d[6:2]);
    bclk_d  = c_d[1];
    pblrc_d = c_d[7];
    req_d   = (c_d == 8'd254);
    ur_d    = latch & ~bus.in_valid;
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      c_q      <= 8'd0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      bclk_q   <= 1'b0;
      pblrc_q  <= 1'b0;
      pbdat_q  <= 1'b0;
      req_q    <= 1'b0;
      ur_q     <= 1'b0;
    end else begin
      c_q      <= c_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      bclk_q   <= bclk_d;
      pblrc_q  <= pblrc_d;
      pbdat_q  <= pbdat_d;
      req_q    <= req_d;
      ur_q     <= ur_d;
    end
  end

  assign bus.bclk       = bclk_q;
  assign bus.pblrc      = pblrc_q;
  assign bus.pbdat      = pbdat_q;
  assign bus.sample_req = req_q;
  assign bus.underrun   = ur_q;

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Bench for i2s_sample_tx: a stereo and a mono instance share clock, reset and stimulus;
// each table row is latched at a frame wrap and its transmitted slots are compared next frame.
module tb_i2s_sample_tx;

  localparam int SB = 16;
  localparam int NV = 6;

  logic mclk = 1'b0;
  logic rst_n;
  always #5 mclk = ~mclk;

  i2s_sample_tx_if #(.SAMPLE_BITS(SB)) bus_s ();
  i2s_sample_tx_if #(.SAMPLE_BITS(SB)) bus_m ();

  i2s_sample_tx #(.SAMPLE_BITS(SB), .MONO(1'b0)) dut_s (
    .mclk(mclk), .rst_n(rst_n), .bus(bus_s.slave)
  );
  i2s_sample_tx #(.SAMPLE_BITS(SB), .MONO(1'b1)) dut_m (
    .mclk(mclk), .rst_n(rst_n), .bus(bus_m.slave)
  );

  typedef struct packed {
    logic [15:0] sl;
    logic [15:0] sr;
    logic        vld;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    logic [15:0] exp_mr;
    logic        exp_ur;
  } vec_t;

  vec_t        vecs [NV];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [7:0]  c_m;
  logic [31:0] ls_buf, rs_buf, ml_buf, mr_buf;
  int          clk_err, req_err, ur_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] sl, input logic [15:0] sr, input logic vld);
    bus_s.sample_l = sl;
    bus_s.sample_r = sr;
    bus_s.in_valid = vld;
    bus_m.sample_l = sl;
    bus_m.sample_r = sr;
    bus_m.in_valid = vld;
  endtask

  function automatic logic [31:0] slot(input logic [15:0] w);
    return {1'b0, w, 15'b0};
  endfunction

  // One mclk: advance the model counter, check clock/pulse lines, capture bclk-rising data.
  task automatic tick();
    int idx;
    @(posedge mclk);
    #1;
    c_m = c_m + 8'd1;
    if (bus_s.bclk !== c_m[1] || bus_s.pblrc !== c_m[7] ||
        bus_m.bclk !== c_m[1] || bus_m.pblrc !== c_m[7]) clk_err++;
    if (bus_s.sample_req !== (c_m == 8'd254) || bus_m.sample_req !== (c_m == 8'd254)) req_err++;
    if (c_m != 8'd0 && (bus_s.underrun !== 1'b0 || bus_m.underrun !== 1'b0)) ur_err++;
    if (c_m[1:0] == 2'd2) begin
      idx = 31 - int'(c_m[6:2]);
      if (c_m[7]) begin
        rs_buf[idx] = bus_s.pbdat;
        mr_buf[idx] = bus_m.pbdat;
      end else begin
        ls_buf[idx] = bus_s.pbdat;
        ml_buf[idx] = bus_m.pbdat;
      end
    end
  endtask

  initial begin
    logic [15:0] el, er, emr;

    vecs[0] = '{16'h8001, 16'h7FFE, 1'b1, 16'h8001, 16'h7FFE, 16'h8001, 1'b0};
    vecs[1] = '{16'h1234, 16'hFFFF, 1'b1, 16'h1234, 16'hFFFF, 16'h1234, 1'b0};
    vecs[2] = '{16'hABCD, 16'h5555, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vecs[3] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0F0F, 16'hF0F0, 16'h0F0F, 1'b0};
    vecs[4] = '{16'h0000, 16'h0001, 1'b1, 16'h0000, 16'h0001, 16'h0000, 1'b0};
    vecs[5] = '{16'hFFFF, 16'h8000, 1'b1, 16'hFFFF, 16'h8000, 16'hFFFF, 1'b0};

    rst_n = 1'b0;
    drive(16'h0, 16'h0, 1'b0);
    c_m = 8'd0;
    repeat (3) @(posedge mclk);
    @(negedge mclk);
    check("reset_outputs",
          {22'd0, bus_s.bclk, bus_s.pblrc, bus_s.pbdat, bus_s.sample_req, bus_s.underrun,
           bus_m.bclk, bus_m.pblrc, bus_m.pbdat, bus_m.sample_req, bus_m.underrun}, 32'd0);
    rst_n = 1'b1;

    for (int f = 0; f <= NV; f++) begin
      ls_buf = '1; rs_buf = '1; ml_buf = '1; mr_buf = '1;
      clk_err = 0; req_err = 0; ur_err = 0;
      for (int k = 1; k <= 255; k++) begin
        tick();
        if (c_m == 8'd100) drive(16'h5A5A, 16'hA5A5, 1'b0);
        if (c_m == 8'd254) begin
          if (f < NV) drive(vecs[f].sl, vecs[f].sr, vecs[f].vld);
          else        drive(16'hFFFF, 16'hFFFF, 1'b1);
        end
      end
      if (f == 0) begin
        el = 16'h0; er = 16'h0; emr = 16'h0;
      end else begin
        el = vecs[f-1].exp_l; er = vecs[f-1].exp_r; emr = vecs[f-1].exp_mr;
      end
      check($sformatf("frame%0d_left", f),       ls_buf, slot(el));
      check($sformatf("frame%0d_right", f),      rs_buf, slot(er));
      check($sformatf("frame%0d_mono_left", f),  ml_buf, slot(el));
      check($sformatf("frame%0d_mono_right", f), mr_buf, slot(emr));
      check($sformatf("frame%0d_clkdiv_errs", f), clk_err, 0);
      check($sformatf("frame%0d_req_errs", f),    req_err, 0);
      check($sformatf("frame%0d_stray_underrun", f), ur_err, 0);
      tick();
      if (f < NV)
        check($sformatf("frame%0d_underrun_at_c0", f),
              {30'd0, bus_s.underrun, bus_m.underrun}, {30'd0, {2{vecs[f].exp_ur}}});
      drive(16'h3C3C, 16'hC3C3, 1'b1);
    end

    // 0xFFFF is now held; reach the left MSB and assert reset between edges.
    clk_err = 0;
    repeat (6) tick();
    check("pre_reset_pbdat", {30'd0, bus_s.pbdat, bus_m.pbdat}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {22'd0, bus_s.bclk, bus_s.pblrc, bus_s.pbdat, bus_s.sample_req, bus_s.underrun,
           bus_m.bclk, bus_m.pblrc, bus_m.pbdat, bus_m.sample_req, bus_m.underrun}, 32'd0);
    @(negedge mclk);
    @(negedge mclk);
    rst_n = 1'b1;
    c_m = 8'd0;
    tick();
    check("bclk_after_release_c1", {31'd0, bus_s.bclk}, 32'd0);
    tick();
    check("bclk_after_release_c2", {31'd0, bus_s.bclk}, 32'd1);
    repeat (4) tick();
    check("hold_discarded_by_reset", {30'd0, bus_s.pbdat, bus_m.pbdat}, 32'd0);
    check("clkdiv_after_reset", clk_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_sample_tx.md
# i2s_sample_tx

I2S transmitter at the far end of each voice's sample path, e.g. the `p_sample_buffer` output of the 808 one-shot voice. It divides `mclk` (256× sample rate) into the codec bit clock and the `pblrc` word clock. It requests and latches one left/right 16-bit pair per frame and serialises it MSB-first in standard Philips I2S format on `pbdat`. It also generates the `pblrc` consumed by the voice's filters.

## Interface
- `SAMPLE_BITS`, 16, sample width; legal range 1..31.
- `MONO`, 0, when 1 the right slot transmits the latched left sample and `sample_r` is ignored.

- `mclk`  in  1  master clock, 256 cycles per audio frame.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `sample_l`  in  SAMPLE_BITS  signed left sample, two's complement.
- `sample_r`  in  SAMPLE_BITS  signed right sample.
- `in_valid`  in  1  the upstream sample pair is valid at the latch edge.
- `sample_req`  out  1  one-cycle request for the next frame's pair.
- `underrun`  out  1  one-cycle pulse when no valid pair was present at the latch edge.
- `bclk`  out  1  bit clock, `mclk`/4.
- `pblrc`  out  1  word clock, `mclk`/256; 0 = left, 1 = right.
- `pbdat`  out  1  serial data.

## Operation
- **Frame counter** `c`: 8 bits; steps +1 every `mclk` edge and wraps 255→0.
- **Bit index** `b = c[7:2]` (0..63); **slot bit** `s = b mod 32`; **channel** = `c[7]`.
- **Holding registers** `hold_l` and `hold_r` are loaded only on the edge where `c` goes 255→0:
  - `in_valid`=1: `hold_l` ← `sample_l`; `hold_r` ← `sample_r`, or `sample_l` if `MONO`=1.
  - `in_valid`=0: both ← 0 (mute); `underrun` is high while `c`=0.
- **`sample_req`** is high exactly while `c`=254.
  - Upstream gets 2 `mclk` cycles to present data; data must be stable at the 255→0 edge.
- **Data mapping**, with `h` = `hold_l` when `c[7]`=0 else `hold_r`:
  - `s`=0: `pbdat`=0. This is the one-bit I2S delay after the `pblrc` edge.
  - 1 ≤ `s` ≤ `SAMPLE_BITS`: `pbdat` = `h[SAMPLE_BITS - s]`, MSB first.
  - `s` > `SAMPLE_BITS`: `pbdat`=0 (padding).
- No FSM beyond the counter. The sequence is free-running and has no stall; upstream never back-pressures.
- **Simultaneous events:** a latch and a read of the hold registers never coincide, because `s`=0 at `c`=0 needs no hold data.

## Timing
- All outputs are registers. After the edge that loads counter value `c`:
  - `bclk` = `c[1]`, `pblrc` = `c[7]`, `pbdat` = map(`c`).
  - `sample_req` = (`c`==254); `underrun` as defined above.
- `bclk` is low for `c[1:0]` ∈ {0,1} and high for {2,3}.
  - `pbdat` and `pblrc` change only on `bclk` falling edges, as the codec samples on rising edges.
- **Reset** (`rst_n`=0, asynchronous): `c`=0, `hold_l`=`hold_r`=0, and every output is 0.
  - First edge after release loads `c`=1.
  - The first frame transmits zeros; the first real latch is at the first 255→0 edge.
- **Reset mid-frame:** all outputs go to 0 immediately, without waiting for `mclk`. Held samples are discarded; there is no partial-frame resume.
- **Latency:** a pair latched at the 255→0 edge has its left MSB on `pbdat` from `c`=4 to 7, 4 `mclk` after the latch.
  - Left LSB at `c`=64..67; right MSB at `c`=132..135; right LSB at `c`=192..195.
- **Width rule:** inputs are not sign-extended into padding; padding bits are always 0.

## Test plan
- **Reset:** hold `rst_n`=0 mid-frame with `pbdat`=1 → all outputs 0 asynchronously; after release, `bclk` first rises on the edge that loads `c`=2.
- **Clock division:** free-run 1024 `mclk` → `bclk` period 4, `pblrc` period 256 with 128 low then 128 high, and `sample_req` exactly 4 pulses spaced 256 apart.
- **Data mapping:** `sample_l`=0x8001, `sample_r`=0x7FFE, `in_valid`=1 → bclk-rising samples give left slot 0,1,0×14,1 then 15 zeros, and right slot 0,0,1×14,0 then 15 zeros.
- **Underrun:** `in_valid`=0 at one latch edge → `underrun` high for exactly 1 cycle at `c`=0 and that frame is all zeros; the next valid frame transmits normally.
- **Mono:** `MONO`=1, `sample_l`=0x1234, `sample_r`=0xFFFF → both slots carry 0x1234.
- **Input stability window:** change `sample_l` at `c`=100 and `c`=254 → only the value present at the 255→0 edge is transmitted.
